fetch_sequencer: RTL and testbench

- Instruction-fetch and next-PC sequencer for the single-cycle MIPS core.
- Sits on the opposite side of the decode interface: it produces OpCode/Funct and the instruction fields for the control decoder, and consumes the decoder's PCSrc choice and the branch outcome to select the next PC.
- Fetches from a request/grant/response instruction memory.
- Presents each instruction under a valid/ready handshake until execute retires it.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/next_pc_calc.sv | 39 +++
 rtl/fetch_sequencer.sv | 100 ++++++++++
 tb/tb_fetch_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch side of the single-cycle MIPS core:
// next-PC select codes, fetch FSM encoding and instruction field positions.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int TARGET_MSB = 25;

  // Sign-extended word offset of a branch immediate, in bytes.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the retiring instruction.
// misaligned flags a register jump whose target has nonzero low bits.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pcPlus4;
  logic        unusedOpcode;

  assign pcPlus4      = pc + 32'd4;
  assign unusedOpcode = ^instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    next_pc    = pcPlus4;
    misaligned = 1'b0;
    case (pc_src)
      PCSRC_SEQ: next_pc = pcPlus4;
      PCSRC_BR: begin
        if (branch_taken) next_pc = pcPlus4 + branchOffset(instr[IMM_MSB:0]);
      end
      PCSRC_J:   next_pc = {pcPlus4[31:28], instr[TARGET_MSB:0], 2'b00};
      PCSRC_JR: begin
        // Low bits are dropped; the caller only sees the misalign pulse.
        next_pc    = {jr_target[31:2], 2'b00};
        misaligned = |jr_target[1:0];
      end
      default: next_pc = pcPlus4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and next-PC sequencer: request/grant/response fetch,
// valid/ready issue to execute, retire counting and jr misalign pulse.
//
// state   | meaning
// S_FETCH | request held on imem until granted
// S_WAIT  | granted, waiting for read data
// S_ISSUE | instruction presented until execute retires it
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic [1:0]         pc_src,
  input  logic               branch_taken,
  input  logic [31:0]        jr_target,
  output logic               misalign,
  output logic [COUNT_W-1:0] retire_count
);

  fetch_state_e state, stateNext;
  logic [31:0]  pcReg, instrReg, nextPc;
  logic         misaligned, retire;

  assign retire = (state == S_ISSUE) && instr_ready;

  next_pc_calc uNextPc (
    .pc           (pcReg),
    .instr        (instrReg),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .next_pc      (nextPc),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= stateNext;
  end

  // A grant seen outside S_FETCH is a memory protocol error and is ignored.
  always_comb begin
    stateNext   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) stateNext = S_ISSUE;
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) stateNext = S_FETCH;
      end
      default: stateNext = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg        <= {RESET_PC[31:2], 2'b00};
      instrReg     <= 32'd0;
      misalign     <= 1'b0;
      retire_count <= '0;
    end else begin
      misalign <= retire && misaligned;
      if (state == S_WAIT && imem_rvalid) instrReg <= imem_rdata;
      if (retire) begin
        pcReg        <= nextPc;
        retire_count <= retire_count + COUNT_W'(1);
      end
    end
  end

  assign imem_addr = pcReg;
  assign pc        = pcReg;
  assign pc_plus4  = pcReg + 32'd4;
  assign instr     = instrReg;
  assign opcode    = instrReg[OPCODE_MSB:OPCODE_LSB];
  assign funct     = instrReg[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, all
// checked each cycle against a transaction-level model of fetch/issue/retire.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc, pc_plus4, jr_target;
  logic [5:0]  opcode, funct;
  logic [1:0]  pc_src;
  logic        branch_taken, misalign;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

  // Model: which step of an instruction's life we are in, plus architectural values.
  bit          mReq, mWait, mValid, mMis;
  logic [31:0] mPc, mInstr, mCount;

  fetch_sequencer #(.RESET_PC(RST_PC), .COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .pc_src(pc_src), .branch_taken(branch_taken), .jr_target(jr_target),
    .misalign(misalign), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] refNextPc(input logic [31:0] p, input logic [31:0] ins,
                                            input logic [1:0] src, input logic bt,
                                            input logic [31:0] jr);
    logic [31:0] p4, off;
    p4  = p + 32'd4;
    off = ins[15] ? (32'hFFFF_0000 | (ins & 32'h0000_FFFF)) : (ins & 32'h0000_FFFF);
    case (src)
      2'd1:    return bt ? p4 + off * 32'd4 : p4;
      2'd2:    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      2'd3:    return jr & 32'hFFFF_FFFC;
      default: return p4;
    endcase
  endfunction

  task automatic modelReset();
    mReq = 1'b1; mWait = 1'b0; mValid = 1'b0; mMis = 1'b0;
    mPc = RST_PC; mInstr = 32'd0; mCount = 32'd0;
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      if (rst_n) chk("imem_req", {31'd0, imem_req}, {31'd0, mReq});
      chk("imem_addr", imem_addr, mPc);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, mValid});
      chk("instr", instr, mInstr);
      chk("opcode", {26'd0, opcode}, {26'd0, mInstr[31:26]});
      chk("funct", {26'd0, funct}, {26'd0, mInstr[5:0]});
      chk("pc", pc, mPc);
      chk("pc_plus4", pc_plus4, mPc + 32'd4);
      chk("misalign", {31'd0, misalign}, {31'd0, mMis});
      chk("retire_count", retire_count, mCount);
    end
  end

  // Drive one cycle of inputs, advance the model, land at negedge+2 of the next cycle.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                      input logic [1:0] src, input logic bt, input logic [31:0] jr);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
    pc_src = src; branch_taken = bt; jr_target = jr;
    mMis = 1'b0;
    if (mReq) begin
      if (g) begin mReq = 1'b0; mWait = 1'b1; end
    end else if (mWait) begin
      if (rv) begin mWait = 1'b0; mValid = 1'b1; mInstr = rd; end
    end else if (mValid && rdy) begin
      mMis   = (src == 2'd3) && (jr[1:0] != 2'b00);
      mPc    = refNextPc(mPc, mInstr, src, bt, jr);
      mCount = mCount + 32'd1;
      mValid = 1'b0; mReq = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic fetchIssue(input logic [31:0] word);
    step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, word, 1'b0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic retireWith(input logic [1:0] src, input logic bt, input logic [31:0] jr);
    step(1'b0, 1'b0, 32'd0, 1'b1, src, bt, jr);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    pc_src = 2'd0; branch_taken = 1'b0; jr_target = 32'd0;
    modelReset();
    cmpOn = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", retire_count, 32'd0);
    rst_n = 1'b1;
    chk("first_addr", imem_addr, 32'h0040_0000);

    fetchIssue(32'h2008_0005);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_opcode", {26'd0, opcode}, 32'h08);
    chk("first_funct", {26'd0, funct}, 32'h05);
    retireWith(2'd0, 1'b0, 32'd0);
    chk("seq_addr", imem_addr, 32'h0040_0004);
    chk("seq_count", retire_count, 32'd1);
    chk("model_seq_pc", mPc, 32'h0040_0004);

    fetchIssue(32'h0000_0008);
    retireWith(2'd3, 1'b0, 32'h0040_0010);
    fetchIssue(32'h1000_FFFC);
    retireWith(2'd1, 1'b1, 32'd0);
    chk("br_taken_pc", pc, 32'h0040_0004);
    chk("model_br_pc", mPc, 32'h0040_0004);

    fetchIssue(32'h0000_0008);
    retireWith(2'd3, 1'b0, 32'h0040_0010);
    fetchIssue(32'h1000_FFFC);
    retireWith(2'd1, 1'b0, 32'd0);
    chk("br_not_taken_pc", pc, 32'h0040_0014);

    fetchIssue(32'h0000_0008);
    retireWith(2'd3, 1'b0, 32'h0040_0020);
    fetchIssue(32'h0810_0000);
    retireWith(2'd2, 1'b0, 32'd0);
    chk("jump_pc", pc, 32'h0040_0000);
    chk("model_jump_pc", mPc, 32'h0040_0000);

    fetchIssue(32'h0000_0008);
    retireWith(2'd3, 1'b0, 32'h0040_0103);
    chk("jr_pc", pc, 32'h0040_0100);
    chk("misalign_on", {31'd0, misalign}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
      chk("misalign_off", {31'd0, misalign}, 32'd0);
      chk("hold_req", {31'd0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, 32'h0040_0100);
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
      chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    step(1'b0, 1'b1, 32'h0000_0020, 1'b0, 2'd0, 1'b0, 32'd0);
    chk("late_valid", {31'd0, instr_valid}, 32'd1);

    retireWith(2'd3, 1'b0, 32'hFFFF_FFFC);
    fetchIssue(32'h0000_0020);
    retireWith(2'd0, 1'b0, 32'd0);
    chk("wrap_pc", pc, 32'h0000_0000);

    step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_count", retire_count, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    @(posedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    fetchIssue(32'h2008_0005);
    chk("restart_pc", pc, RST_PC);

    for (int i = 0; i < 3000; i++) begin
      logic g, rv, rdy, bt;
      logic [1:0] src;
      logic [31:0] jr;
      g   = mReq ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      rv  = mWait ? ($urandom_range(2) == 0) : 1'b0;
      rdy = $urandom_range(1) == 1;
      src = 2'($urandom_range(3));
      bt  = $urandom_range(1) == 1;
      jr  = $urandom;
      if ($urandom_range(3) == 0) jr = jr & 32'hFFFF_FFFC;
      if ($urandom_range(15) == 0) jr = 32'hFFFF_FFFC;
      step(g, rv, $urandom, rdy, src, bt, jr);
    end

    cmpOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
